// File: rtl/mixer_egress_if.sv
// Mixer-core frame bus and DAC sample stream, bundled for the egress stage.
interface mixer_egress_if #(
    parameter int AUDIO_WIDTH_P   = 24,
    parameter int DAC_WIDTH_P     = 24,
    parameter int NR_OF_OUTPUTS_P = 2
);
    logic [NR_OF_OUTPUTS_P-1:0][AUDIO_WIDTH_P-1:0] mix_data;
    logic                                          mix_valid;
    logic                                          mix_ready;
    logic                                          mix_clip;
    logic [DAC_WIDTH_P-1:0]                        dac_data;
    logic                                          dac_valid;
    logic                                          dac_ready;
    logic                                          dac_last;

    // Egress stage: accepts frames from the mixer core and drives the DAC stream
    modport master (
        input  mix_data, mix_valid, mix_clip, dac_ready,
        output mix_ready, dac_data, dac_valid, dac_last
    );

    // Surroundings: mixer core supplies frames, DAC sink supplies ready
    modport slave (
        output mix_data, mix_valid, mix_clip, dac_ready,
        input  mix_ready, dac_data, dac_valid, dac_last
    );
endinterface

// File: rtl/mixer_egress.sv
// Egress stage between mixer core and DAC: captures one multi-lane frame,
// serialises it lane by lane with last on the final lane, converts sample
// width, tracks per-lane peaks, counts dropped frames and drives a clip LED.
module mixer_egress #(
    parameter int AUDIO_WIDTH_P      = 24,
    parameter int DAC_WIDTH_P        = 24,
    parameter int NR_OF_OUTPUTS_P    = 2,
    parameter int CLIP_HOLD_CYCLES_P = 625000000,
    parameter int BLINK_BIT_P        = 25,
    parameter int OVERRUN_WIDTH_P    = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    mixer_egress_if.master                                bus,
    input  logic                                          cmd_clear_status,
    output logic [NR_OF_OUTPUTS_P-1:0][AUDIO_WIDTH_P-1:0] sr_peak_max,
    output logic [NR_OF_OUTPUTS_P-1:0][AUDIO_WIDTH_P-1:0] sr_peak_min,
    output logic                                          sr_overrun,
    output logic [OVERRUN_WIDTH_P-1:0]                    sr_overrun_count,
    output logic                                          clip_led
);

    localparam int IDX_W = (NR_OF_OUTPUTS_P > 1) ? $clog2(NR_OF_OUTPUTS_P) : 1;
    localparam int CNT_W = $clog2(CLIP_HOLD_CYCLES_P);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [IDX_W-1:0]         LAST_IDX      = IDX_W'(NR_OF_OUTPUTS_P - 1);
    localparam logic [CNT_W-1:0]         HOLD_LOAD     = CNT_W'(CLIP_HOLD_CYCLES_P - 1);
    localparam logic [AUDIO_WIDTH_P-1:0] PEAK_MAX_INIT = {1'b1, {(AUDIO_WIDTH_P-1){1'b0}}};
    localparam logic [AUDIO_WIDTH_P-1:0] PEAK_MIN_INIT = {1'b0, {(AUDIO_WIDTH_P-1){1'b1}}};
    localparam logic [OVERRUN_WIDTH_P-1:0] OVR_SAT     = {OVERRUN_WIDTH_P{1'b1}};

    logic [0:0]                                    state;
    logic [NR_OF_OUTPUTS_P-1:0][AUDIO_WIDTH_P-1:0] frame_buf;
    logic [IDX_W-1:0]                              idx;
    logic [IDX_W-1:0]                              idx_next;
    logic [AUDIO_WIDTH_P-1:0]                      send_sample;
    logic [AUDIO_WIDTH_P-1:0]                      next_sample;
    logic [DAC_WIDTH_P-1:0]                        next_word;
    logic                                          capture;
    logic                                          drop;
    logic [CNT_W-1:0]                              hold_cnt;
    logic [CNT_W-1:0]                              hold_next;

    assign capture  = (state == ST_IDLE) && bus.mix_valid;
    assign drop     = (state == ST_SEND) && bus.mix_valid;
    assign idx_next = idx + 1'b1;

    // The lane following the one currently on the stream; a single-lane
    // frame never advances, so it just points at lane 0.
    if (NR_OF_OUTPUTS_P == 1) begin : g_single_lane
        assign send_sample = frame_buf[0];
    end else begin : g_multi_lane
        assign send_sample = frame_buf[idx_next];
    end

    // Lane 0 goes straight from the mixer input so it leaves on the capture edge.
    assign next_sample = (state == ST_IDLE) ? bus.mix_data[0] : send_sample;

    // Width conversion: left-justify when widening, keep the top bits
    // (arithmetic shift, rounds toward negative infinity) when narrowing.
    if (DAC_WIDTH_P == AUDIO_WIDTH_P) begin : g_conv_pass
        assign next_word = next_sample;
    end else if (DAC_WIDTH_P > AUDIO_WIDTH_P) begin : g_conv_widen
        assign next_word = {next_sample, {(DAC_WIDTH_P-AUDIO_WIDTH_P){1'b0}}};
    end else begin : g_conv_narrow
        logic [AUDIO_WIDTH_P-DAC_WIDTH_P-1:0] unused_lsbs;
        assign unused_lsbs = next_sample[AUDIO_WIDTH_P-DAC_WIDTH_P-1:0];
        assign next_word   = next_sample[AUDIO_WIDTH_P-1 -: DAC_WIDTH_P];
    end

    // Frame capture and lane-by-lane serialisation onto the DAC stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.mix_ready <= 1'b1;
            bus.dac_valid <= 1'b0;
            bus.dac_last  <= 1'b0;
            bus.dac_data  <= '0;
            idx           <= '0;
            frame_buf     <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.mix_valid) begin
                frame_buf     <= bus.mix_data;
                bus.dac_data  <= next_word;
                bus.dac_valid <= 1'b1;
                bus.dac_last  <= (NR_OF_OUTPUTS_P == 1);
                idx           <= '0;
                state         <= ST_SEND;
                bus.mix_ready <= 1'b0;
            end
        end else begin
            if (bus.dac_valid && bus.dac_ready) begin
                if (bus.dac_last) begin
                    bus.dac_valid <= 1'b0;
                    bus.dac_last  <= 1'b0;
                    idx           <= '0;
                    state         <= ST_IDLE;
                    bus.mix_ready <= 1'b1;
                end else begin
                    idx          <= idx_next;
                    bus.dac_data <= next_word;
                    bus.dac_last <= (idx_next == LAST_IDX);
                end
            end
        end
    end

    // Status: peaks from captured frames, dropped-frame tracking; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_peak_max      <= {NR_OF_OUTPUTS_P{PEAK_MAX_INIT}};
            sr_peak_min      <= {NR_OF_OUTPUTS_P{PEAK_MIN_INIT}};
            sr_overrun       <= 1'b0;
            sr_overrun_count <= '0;
        end else if (cmd_clear_status) begin
            sr_peak_max      <= {NR_OF_OUTPUTS_P{PEAK_MAX_INIT}};
            sr_peak_min      <= {NR_OF_OUTPUTS_P{PEAK_MIN_INIT}};
            sr_overrun       <= 1'b0;
            sr_overrun_count <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NR_OF_OUTPUTS_P; i++) begin
                    if ($signed(bus.mix_data[i]) > $signed(sr_peak_max[i])) begin
                        sr_peak_max[i] <= bus.mix_data[i];
                    end
                    if ($signed(bus.mix_data[i]) < $signed(sr_peak_min[i])) begin
                        sr_peak_min[i] <= bus.mix_data[i];
                    end
                end
            end
            if (drop) begin
                sr_overrun <= 1'b1;
                if (sr_overrun_count != OVR_SAT) begin
                    sr_overrun_count <= sr_overrun_count + 1'b1;
                end
            end
        end
    end

    // Next hold-counter value: a clip reloads the full window, else count down.
    always_comb begin
        hold_next = hold_cnt;
        if (bus.mix_clip) begin
            hold_next = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - 1'b1;
        end
    end

    // Hold counter and blinking LED, both registered from the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            clip_led <= 1'b0;
        end else begin
            hold_cnt <= hold_next;
            clip_led <= (hold_next != '0) & hold_next[BLINK_BIT_P];
        end
    end

endmodule
